store_merge_unit: RTL
=====================

Name: store_merge_unit

Overview:
Multicycle store-path unit. It is the write-direction counterpart of the load-extend/writeback path: it takes register data (rt) plus a byte address and a store size (SW/SH/SB), and drives the data memory. SW writes the word directly. SB and SH do a read-modify-write: read the word, merge the byte/half, write the word back. It sits between the control FSM and the data memory port, replacing the direct register-to-memory write.

Parameters:
MEM_LATENCY, 1, cycles from mem_addr presented (mem_wr=0) to mem_rdata valid; legal range 1..7.

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request a store; sampled only in IDLE
store_type  input  2  2'b00 SW, 2'b01 SH, 2'b10 SB, 2'b11 reserved
addr  input  32  byte address of the store
rt_data  input  32  register data to store
mem_rdata  input  32  data memory read word
mem_addr  output  32  word-aligned memory address {addr_q[31:2],2'b00}
mem_wr  output  1  memory write enable, one cycle per store
mem_wdata  output  32  word written to memory
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when the store completes
misaligned  output  1  one-cycle pulse with done on alignment fault (see Optional Feature)

Behaviour:
- Reset: state=IDLE; mem_addr, mem_wdata, the latched addr/data/type, and the wait counter all =0; mem_wr, busy, done, misaligned all =0.
- Reset asserted in any state returns to IDLE on that edge; mem_wr is low from the next cycle; no partial or late write occurs.
- States: IDLE, READ, WAIT, WRITE, DONE.
- IDLE: on start=1, latch addr, rt_data and store_type.
  - SW goes to WRITE.
  - SH/SB go to READ.
  - Reserved type goes to DONE with no memory access.
  - start=0 stays in IDLE.
- start is ignored while busy; no queueing.
- READ (1 cycle): mem_addr driven, mem_wr=0; load counter with MEM_LATENCY; go to WAIT.
- WAIT: decrement counter each cycle. In the cycle the counter reaches 1, capture mem_rdata into the merge buffer and go to WRITE. WAIT lasts exactly MEM_LATENCY cycles.
- WRITE (1 cycle): mem_wr=1, mem_addr unchanged, mem_wdata per merge rule; go to DONE.
- DONE (1 cycle): done=1, mem_wr=0; go to IDLE. A new start is accepted in the cycle after DONE.
- Merge rule (little-endian):
  - SW: wdata=rt_data.
  - SH: addr[1]=0 gives {rd[31:16],rt[15:0]}; addr[1]=1 gives {rt[15:0],rd[15:0]}.
  - SB: rt[7:0] replaces byte lane addr[1:0]; other lanes come from rd.
- Latency from start edge to done high:
  - SW: 2 cycles.
  - SH/SB: 3+MEM_LATENCY cycles (4 at default).
  - Reserved type: 1 cycle.
- mem_addr and mem_wdata hold their last values in IDLE/DONE. Only mem_wr qualifies a write.

Optional Feature:
STORE_ALIGN_CHECK_EN.
- Defined: in IDLE, a start with SH and addr[0]=1, or SW and addr[1:0]!=0, goes straight to DONE. In that case done=1, misaligned=1, and there is no read and no mem_wr.
- Undefined: misaligned is tied 0. SH ignores addr[0]; SW ignores addr[1:0]. The access proceeds to the word-aligned address.

Test Plan:
- SW, addr=0x10, rt=0xDEADBEEF -> cycle 1: mem_wr=1, mem_addr=0x10, wdata=0xDEADBEEF; cycle 2: done=1; no read phase.
- SB, addr=0x13, rt=0x000000AB, memory word 0x11223344, MEM_LATENCY=1 -> mem_addr=0x10; wdata=0xAB223344; mem_wr in cycle 3; done in cycle 4.
- SH, addr=0x22, rt=0x1234CAFE, memory 0xAABBCCDD -> mem_addr=0x20, wdata=0xCAFECCDD. Repeat at addr=0x20 -> wdata=0xAABBCAFE.
- start pulsed again during WAIT -> ignored; exactly one mem_wr; busy stays high until done.
- reset asserted during WAIT of an SB -> next cycle state=IDLE, busy=0, and mem_wr never asserts. Reserved type 2'b11 -> done 1 cycle after start, no mem_wr.
- With STORE_ALIGN_CHECK_EN: SH addr=0x21 -> done=1 and misaligned=1 one cycle after start, mem_wr never asserts. Without the macro: same stimulus -> wdata upper half replaced? No: addr[1]=0 -> {rd[31:16],rt[15:0]} at mem_addr=0x20, misaligned=0.

Source files
------------

// File: rtl/store_merge_unit.sv
// Store path between the control FSM and data memory: SW writes directly, SH/SB
// read-modify-write the containing word. Optional STORE_ALIGN_CHECK_EN faults misaligned SH/SW.
module store_merge_unit #(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  store_type,
  input  logic [31:0] addr,
  input  logic [31:0] rt_data,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        misaligned,
  output logic [2:0]  state_dbg
);

  // Handshake: start is taken only while busy=0; the request completes with a
  // single-cycle done pulse, after which busy drops and a new start may be taken.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [1:0] ST_SW = 2'b00;
  localparam logic [1:0] ST_SH = 2'b01;
  localparam logic [1:0] ST_SB = 2'b10;
  localparam logic [2:0] LAT   = 3'(MEM_LATENCY);

  state_t      state;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [1:0]  type_q;
  logic [2:0]  cnt;
  logic        align_fault;

`ifdef STORE_ALIGN_CHECK_EN
  assign align_fault = (store_type == ST_SH && addr[0]) ||
                       (store_type == ST_SW && addr[1:0] != 2'b00);
`else
  assign align_fault = 1'b0;
`endif

  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  // Little-endian lane merge of register data into the word read from memory.
  function automatic logic [31:0] merge(input logic [1:0] t, input logic [1:0] a,
                                        input logic [31:0] rt, input logic [31:0] rd);
    logic [31:0] w;
    w = rd;
    if (t == ST_SH) begin
      if (a[1]) w[31:16] = rt[15:0];
      else      w[15:0]  = rt[15:0];
    end else begin
      w[{a, 3'b000} +: 8] = rt[7:0];
    end
    return w;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      type_q     <= '0;
      cnt        <= '0;
      mem_wdata  <= '0;
      mem_wr     <= 1'b0;
      done       <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      mem_wr     <= 1'b0;
      done       <= 1'b0;
      misaligned <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            addr_q <= addr;
            data_q <= rt_data;
            type_q <= store_type;
            if (align_fault) begin
              state      <= DONE;
              done       <= 1'b1;
              misaligned <= 1'b1;
            end else begin
              case (store_type)
                ST_SW: begin
                  state     <= WRITE;
                  mem_wr    <= 1'b1;
                  mem_wdata <= rt_data;
                end
                ST_SH, ST_SB: state <= READ;
                default: begin
                  state <= DONE;
                  done  <= 1'b1;
                end
              endcase
            end
          end
        end
        READ: begin
          cnt   <= LAT;
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt - 3'd1;
          // Read data is valid in the last WAIT cycle; merge and write next.
          if (cnt == 3'd1) begin
            mem_wdata <= merge(type_q, addr_q[1:0], data_q, mem_rdata);
            mem_wr    <= 1'b1;
            state     <= WRITE;
          end
        end
        WRITE: begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
